// File: rtl/axis_detector_pkg.sv
// Shared definitions for the detector-stream arbiter: FSM encoding and
// the helper that sizes the source-index fields.
package axis_detector_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   // A single source still needs a 1-bit index field, so never return 0.
   function automatic int unsigned src_idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axis_detector_rr_select.sv
// Combinational round-robin picker: first requesting source found when
// searching circularly from the source after the last grant.
module axis_detector_rr_select #(
   parameter int NUM_SRC = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   grant,
   output logic               grant_valid
);

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         if (req[(int'(last_grant) + k) % NUM_SRC]) begin
            grant       = IDX_W'((int'(last_grant) + k) % NUM_SRC);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_detector_arbiter.sv
// Merges several detector-reader AXI-Stream sources into one output with
// round-robin fairness, an optional per-acquisition event limit and a counter.
module axis_detector_arbiter
   import axis_detector_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 128
) (
   input  logic                                  aclk,
   input  logic                                  areset,
   input  logic                                  cfg_enable,
   input  logic [31:0]                           cfg_limit,
   output logic [31:0]                           sts_data,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic [NUM_SRC-1:0]                    s_axis_tvalid,
   output logic [NUM_SRC-1:0]                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
   output logic [src_idx_width(NUM_SRC)-1:0]     m_axis_tuser,
   output logic                                  m_axis_tvalid,
   input  logic                                  m_axis_tready
);

   localparam int IDX_W = src_idx_width(NUM_SRC);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_SRC - 1);

   state_t                 state;
   logic [IDX_W-1:0]       last_grant;
   logic [IDX_W-1:0]       sel_grant;
   logic                   sel_valid;
   logic                   grant_now;
   logic [DATA_WIDTH-1:0]  sel_word;
   logic [31:0]            cnt_inc;
   logic [31:0]            cnt_sat;

   axis_detector_rr_select #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_rr_select (
      .req         (s_axis_tvalid),
      .last_grant  (last_grant),
      .grant       (sel_grant),
      .grant_valid (sel_valid)
   );

   assign grant_now = !areset && (state == ARB) && cfg_enable && sel_valid;
   assign cnt_inc   = sts_data + 32'd1;
   assign cnt_sat   = (sts_data == 32'hFFFF_FFFF) ? sts_data : cnt_inc;

   always_comb begin
      s_axis_tready = '0;
      if (grant_now) begin
         s_axis_tready[sel_grant] = 1'b1;
      end
   end

   always_comb begin
      sel_word = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel_grant == IDX_W'(i)) begin
            sel_word = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Grant and capture share one edge, so the output word appears the cycle
   // after the source handshake; SEND always finishes before honouring disable.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state         <= IDLE;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
         sts_data      <= '0;
         last_grant    <= LAST_INIT;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_enable) begin
                  state    <= ARB;
                  sts_data <= '0;
               end
            end
            ARB: begin
               if (!cfg_enable) begin
                  state <= IDLE;
               end else if (sel_valid) begin
                  m_axis_tdata  <= sel_word;
                  m_axis_tuser  <= sel_grant;
                  m_axis_tvalid <= 1'b1;
                  last_grant    <= sel_grant;
                  state         <= SEND;
               end
            end
            SEND: begin
               if (m_axis_tready) begin
                  m_axis_tvalid <= 1'b0;
                  sts_data      <= cnt_sat;
                  if ((cfg_limit != 32'd0) && (cnt_inc == cfg_limit)) begin
                     state <= DONE;
                  end else if (!cfg_enable) begin
                     state <= IDLE;
                  end else begin
                     state <= ARB;
                  end
               end
            end
            DONE: begin
               m_axis_tvalid <= 1'b0;
               if (!cfg_enable) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_detector_arbiter.sv
// Scoreboard bench for axis_detector_arbiter: expected words are queued as
// traffic is set up and popped by a monitor at each output handshake.
module tb_axis_detector_arbiter;

   localparam int NUM_SRC    = 4;
   localparam int DATA_WIDTH = 128;

   typedef struct {
      logic [1:0]            user;
      logic [DATA_WIDTH-1:0] data;
   } exp_t;

   logic                          aclk;
   logic                          areset;
   logic                          cfg_enable;
   logic [31:0]                   cfg_limit;
   logic [31:0]                   sts_data;
   logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
   logic [NUM_SRC-1:0]            s_axis_tvalid;
   logic [NUM_SRC-1:0]            s_axis_tready;
   logic [DATA_WIDTH-1:0]         m_axis_tdata;
   logic [1:0]                    m_axis_tuser;
   logic                          m_axis_tvalid;
   logic                          m_axis_tready;

   logic [DATA_WIDTH-1:0] src_word [NUM_SRC];
   exp_t                  exp_q [$];
   exp_t                  mon_e;
   int                    hs_cycles [$];
   int                    tests_run    = 0;
   int                    tests_failed = 0;
   int                    hs_count     = 0;
   int                    grant_count  = 0;
   int                    cycle        = 0;

   axis_detector_arbiter #(
      .NUM_SRC    (NUM_SRC),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .cfg_enable    (cfg_enable),
      .cfg_limit     (cfg_limit),
      .sts_data      (sts_data),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   always @(posedge aclk) cycle++;

   always_comb begin
      s_axis_tdata = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = src_word[i];
      end
   end

   function automatic logic [DATA_WIDTH-1:0] word_of(input int i);
      return {32'hDE7E_C700 + 32'(i), 32'h0BAD_F00D ^ 32'(i << 4),
              32'(i * 7 + 3), 32'hA5A5_0000 + 32'(i)};
   endfunction

   function automatic exp_t mk_exp(input int i);
      exp_t e;
      e.user = 2'(i);
      e.data = word_of(i);
      return e;
   endfunction

   // Monitor: ready must be one-hot and only toward a valid source; every
   // output handshake is matched against the head of the expected queue.
   always @(negedge aclk) begin
      if (!areset) begin
         tests_run++;
         if (!$onehot0(s_axis_tready) || ((s_axis_tready & ~s_axis_tvalid) != '0)) begin
            tests_failed++;
            $display("[TB] FAIL tready_legal: tready=%b tvalid=%b, required one-hot subset of valid",
                     s_axis_tready, s_axis_tvalid);
         end
         if (s_axis_tready != '0) grant_count++;
         if (m_axis_tvalid && m_axis_tready) begin
            hs_count++;
            hs_cycles.push_back(cycle);
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL unexpected_word: got tuser=%0d tdata=%h, required no transfer",
                        m_axis_tuser, m_axis_tdata);
            end else begin
               mon_e = exp_q.pop_front();
               if (m_axis_tuser !== mon_e.user || m_axis_tdata !== mon_e.data) begin
                  tests_failed++;
                  $display("[TB] FAIL out_word: got tuser=%0d tdata=%h, required tuser=%0d tdata=%h",
                           m_axis_tuser, m_axis_tdata, mon_e.user, mon_e.data);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic apply_reset();
      areset        = 1'b1;
      cfg_enable    = 1'b0;
      cfg_limit     = 32'd0;
      s_axis_tvalid = '0;
      m_axis_tready = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) src_word[i] = word_of(i);
      tick(2);
      areset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      areset = 1'b1;
      tick(1);
      tests_run += 5;
      if (m_axis_tvalid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL reset_tvalid: got %b, required 0", m_axis_tvalid);
      end
      if (m_axis_tdata !== '0) begin
         tests_failed++; $display("[TB] FAIL reset_tdata: got %h, required 0", m_axis_tdata);
      end
      if (m_axis_tuser !== 2'd0) begin
         tests_failed++; $display("[TB] FAIL reset_tuser: got %0d, required 0", m_axis_tuser);
      end
      if (sts_data !== 32'd0) begin
         tests_failed++; $display("[TB] FAIL reset_sts: got %0d, required 0", sts_data);
      end
      if (s_axis_tready !== '0) begin
         tests_failed++; $display("[TB] FAIL reset_tready: got %b, required 0000", s_axis_tready);
      end
      areset = 1'b0;
   endtask

   task automatic test_single_source();
      exp_t e;
      apply_reset();
      src_word[2]   = 128'hA5;
      e.user        = 2'd2;
      e.data        = 128'hA5;
      exp_q.push_back(e);
      s_axis_tvalid = 4'b0100;
      m_axis_tready = 1'b1;
      cfg_enable    = 1'b1;
      tick(1);
      tests_run++;
      if (s_axis_tready !== 4'b0100) begin
         tests_failed++; $display("[TB] FAIL single_grant: got %b, required 0100", s_axis_tready);
      end
      tick(1);
      s_axis_tvalid = '0;
      tests_run += 4;
      if (m_axis_tvalid !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL single_tvalid: got %b, required 1", m_axis_tvalid);
      end
      if (m_axis_tdata !== 128'hA5) begin
         tests_failed++; $display("[TB] FAIL single_tdata: got %h, required a5", m_axis_tdata);
      end
      if (m_axis_tuser !== 2'd2) begin
         tests_failed++; $display("[TB] FAIL single_tuser: got %0d, required 2", m_axis_tuser);
      end
      if (s_axis_tready !== '0) begin
         tests_failed++; $display("[TB] FAIL single_grant_once: got %b, required 0000", s_axis_tready);
      end
      tick(1);
      tests_run += 2;
      if (sts_data !== 32'd1) begin
         tests_failed++; $display("[TB] FAIL single_sts: got %0d, required 1", sts_data);
      end
      if (m_axis_tvalid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL single_tvalid_drop: got %b, required 0", m_axis_tvalid);
      end
      cfg_enable = 1'b0;
      tick(1);
   endtask

   task automatic test_round_robin();
      int hs0;
      apply_reset();
      hs0 = hs_count;
      hs_cycles.delete();
      for (int k = 0; k < 6; k++) exp_q.push_back(mk_exp(k % NUM_SRC));
      s_axis_tvalid = '1;
      m_axis_tready = 1'b1;
      cfg_enable    = 1'b1;
      for (int c = 0; c < 40 && (hs_count - hs0) < 6; c++) tick(1);
      cfg_enable    = 1'b0;
      s_axis_tvalid = '0;
      tests_run++;
      if (hs_count - hs0 !== 6) begin
         tests_failed++; $display("[TB] FAIL rr_count: got %0d events, required 6", hs_count - hs0);
      end
      for (int k = 1; k < hs_cycles.size(); k++) begin
         tests_run++;
         if (hs_cycles[k] - hs_cycles[k-1] !== 2) begin
            tests_failed++;
            $display("[TB] FAIL rr_spacing: got %0d cycles, required 2", hs_cycles[k] - hs_cycles[k-1]);
         end
      end
      tick(2);
      tests_run++;
      if (exp_q.size() !== 0) begin
         tests_failed++; $display("[TB] FAIL rr_pending: got %0d left, required 0", exp_q.size());
      end
   endtask

   task automatic test_limit();
      int hs0;
      int g0;
      apply_reset();
      hs0 = hs_count;
      g0  = grant_count;
      for (int k = 0; k < 3; k++) exp_q.push_back(mk_exp(k));
      cfg_limit     = 32'd3;
      s_axis_tvalid = '1;
      m_axis_tready = 1'b1;
      cfg_enable    = 1'b1;
      tick(20);
      tests_run += 4;
      if (hs_count - hs0 !== 3) begin
         tests_failed++; $display("[TB] FAIL limit_events: got %0d, required 3", hs_count - hs0);
      end
      if (grant_count - g0 !== 3) begin
         tests_failed++; $display("[TB] FAIL limit_grants: got %0d, required 3", grant_count - g0);
      end
      if (sts_data !== 32'd3) begin
         tests_failed++; $display("[TB] FAIL limit_sts: got %0d, required 3", sts_data);
      end
      if (m_axis_tvalid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL limit_tvalid: got %b, required 0", m_axis_tvalid);
      end
      cfg_enable = 1'b0;
      tick(1);
      s_axis_tvalid = '0;
      cfg_enable    = 1'b1;
      tick(1);
      tests_run++;
      if (sts_data !== 32'd0) begin
         tests_failed++; $display("[TB] FAIL limit_restart_sts: got %0d, required 0", sts_data);
      end
      cfg_enable = 1'b0;
      cfg_limit  = 32'd0;
      tick(1);
   endtask

   task automatic test_backpressure();
      int hs0;
      apply_reset();
      hs0 = hs_count;
      exp_q.push_back(mk_exp(0));
      s_axis_tvalid = '1;
      cfg_enable    = 1'b1;
      tick(2);
      for (int c = 0; c < 10; c++) begin
         tests_run++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 2'd0 || m_axis_tdata !== word_of(0)
             || s_axis_tready !== '0) begin
            tests_failed++;
            $display("[TB] FAIL stall_hold: got tvalid=%b tuser=%0d tdata=%h tready=%b, required 1/0/%h/0000",
                     m_axis_tvalid, m_axis_tuser, m_axis_tdata, s_axis_tready, word_of(0));
         end
         tick(1);
      end
      m_axis_tready = 1'b1;
      cfg_enable    = 1'b0;
      s_axis_tvalid = '0;
      tick(2);
      tests_run += 2;
      if (hs_count - hs0 !== 1) begin
         tests_failed++; $display("[TB] FAIL stall_release: got %0d events, required 1", hs_count - hs0);
      end
      if (m_axis_tvalid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL stall_tvalid: got %b, required 0", m_axis_tvalid);
      end
      m_axis_tready = 1'b0;
   endtask

   task automatic test_disable_in_send();
      apply_reset();
      exp_q.push_back(mk_exp(1));
      s_axis_tvalid = 4'b0010;
      cfg_enable    = 1'b1;
      tick(2);
      cfg_enable    = 1'b0;
      s_axis_tvalid = '0;
      tick(3);
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 2'd1) begin
         tests_failed++;
         $display("[TB] FAIL disable_hold: got tvalid=%b tuser=%0d, required 1/1", m_axis_tvalid, m_axis_tuser);
      end
      m_axis_tready = 1'b1;
      tick(1);
      tests_run += 2;
      if (m_axis_tvalid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL disable_done: got %b, required 0", m_axis_tvalid);
      end
      if (sts_data !== 32'd1) begin
         tests_failed++; $display("[TB] FAIL disable_sts: got %0d, required 1", sts_data);
      end
      m_axis_tready = 1'b0;
      cfg_enable    = 1'b1;
      tick(1);
      tests_run++;
      if (sts_data !== 32'd0) begin
         tests_failed++; $display("[TB] FAIL disable_idle: got sts %0d, required 0", sts_data);
      end
      cfg_enable = 1'b0;
      tick(1);
   endtask

   task automatic test_reset_mid_send();
      int hs0;
      apply_reset();
      exp_q.push_back(mk_exp(0));
      s_axis_tvalid = '1;
      m_axis_tready = 1'b1;
      cfg_enable    = 1'b1;
      tick(3);
      m_axis_tready = 1'b0;
      tick(1);
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 2'd1 || sts_data !== 32'd1) begin
         tests_failed++;
         $display("[TB] FAIL pre_reset: got tvalid=%b tuser=%0d sts=%0d, required 1/1/1",
                  m_axis_tvalid, m_axis_tuser, sts_data);
      end
      areset = 1'b1;
      tick(1);
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || sts_data !== 32'd0 || m_axis_tdata !== '0) begin
         tests_failed++;
         $display("[TB] FAIL midsend_reset: got tvalid=%b sts=%0d tdata=%h, required 0/0/0",
                  m_axis_tvalid, sts_data, m_axis_tdata);
      end
      areset        = 1'b0;
      m_axis_tready = 1'b1;
      hs0           = hs_count;
      exp_q.push_back(mk_exp(0));
      for (int c = 0; c < 10 && (hs_count - hs0) < 1; c++) tick(1);
      cfg_enable    = 1'b0;
      s_axis_tvalid = '0;
      tests_run++;
      if (hs_count - hs0 !== 1) begin
         tests_failed++; $display("[TB] FAIL post_reset_event: got %0d, required 1", hs_count - hs0);
      end
      tick(2);
   endtask

   initial begin
      areset        = 1'b1;
      cfg_enable    = 1'b0;
      cfg_limit     = 32'd0;
      s_axis_tvalid = '0;
      m_axis_tready = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) src_word[i] = word_of(i);
      test_reset();
      test_single_source();
      test_round_robin();
      test_limit();
      test_backpressure();
      test_disable_in_send();
      test_reset_mid_send();
      tests_run++;
      if (exp_q.size() !== 0) begin
         tests_failed++; $display("[TB] FAIL final_pending: got %0d left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
